// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the execute-stage ALU.
package alu_pkg;

    localparam int WORD = 32;
    localparam int IMM  = 16;
    localparam int OPW  = 5;

    typedef enum logic [OPW-1:0] {
        OP_SLA   = 5'h00,
        OP_SRAI  = 5'h01,
        OP_ADD   = 5'h02,
        OP_SUB   = 5'h03,
        OP_MULT  = 5'h04,
        OP_DIV   = 5'h05,
        OP_ADDI  = 5'h06,
        OP_ADDU  = 5'h07,
        OP_SUBU  = 5'h08,
        OP_MULTU = 5'h09,
        OP_DIVU  = 5'h0A,
        OP_ADDIU = 5'h0B,
        OP_SQRT  = 5'h0C,
        OP_AND   = 5'h0D,
        OP_OR    = 5'h0E,
        OP_NOR   = 5'h0F,
        OP_XOR   = 5'h10,
        OP_XNOR  = 5'h11,
        OP_ANDI  = 5'h12,
        OP_ORI   = 5'h13,
        OP_SLT   = 5'h14,
        OP_SLTI  = 5'h15
    } alu_op_e;

endpackage

// File: rtl/alu_isqrt.sv
// Combinational digit-by-digit integer square root: root = floor(sqrt(radicand)).
module alu_isqrt
    import alu_pkg::*;
(
    input  logic [WORD-1:0]   radicand,
    output logic [WORD/2-1:0] root
);

    logic [WORD+1:0]   rem;
    logic [WORD+1:0]   trial;
    logic [WORD/2-1:0] acc;

    // One result bit per pair of radicand bits, most significant pair first.
    always_comb begin
        rem   = '0;
        trial = '0;
        acc   = '0;
        for (int i = WORD/2 - 1; i >= 0; i--) begin
            rem   = {rem[WORD-1:0], radicand[2*i +: 2]};
            trial = {16'b0, acc, 2'b01};
            if (rem >= trial) begin
                rem = rem - trial;
                acc = {acc[WORD/2-2:0], 1'b1};
            end else begin
                acc = {acc[WORD/2-2:0], 1'b0};
            end
        end
    end

    assign root = acc;

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style ALU: combinational opcode case feeding a single register bank (1-cycle latency).
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WORD-1:0]  a,
    input  logic [WORD-1:0]  b,
    input  logic [IMM-1:0]   immediate,
    input  logic [OPW-1:0]   opcode,
    output logic [WORD-1:0]  c,
    output logic [WORD-1:0]  HI,
    output logic [WORD-1:0]  LO,
    output logic             zero,
    output logic             overflow,
    output logic             neg
);

    alu_op_e         op;
    logic [WORD-1:0] sext_imm, zext_imm, op_b;
    logic [WORD-1:0] sum, diff;
    logic [63:0]     prod_s, prod_u;
    logic [WORD-1:0] abs_a, abs_b, div_n, div_d, div_d_safe, quo_u, rem_u;
    logic [WORD/2-1:0] sqrt_root;

    logic [WORD-1:0] reg_A, reg_B, reg_C;
    logic [WORD-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [WORD-1:0] result_d;
    logic            overflow_q, overflow_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;

    assign op       = alu_op_e'(opcode);
    assign sext_imm = {{(WORD-IMM){immediate[IMM-1]}}, immediate};
    assign zext_imm = {{(WORD-IMM){1'b0}}, immediate};

    always_comb begin
        op_b = b;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI: op_b = sext_imm;
            OP_ANDI, OP_ORI:            op_b = zext_imm;
            default:                    op_b = b;
        endcase
    end

    assign sum    = a + op_b;
    assign diff   = a - op_b;
    assign prod_s = {{WORD{a[WORD-1]}}, a} * {{WORD{b[WORD-1]}}, b};
    assign prod_u = {{WORD{1'b0}}, a} * {{WORD{1'b0}}, b};

    // One shared unsigned divider; signed div runs on magnitudes and fixes signs afterwards.
    assign abs_a      = a[WORD-1] ? -a : a;
    assign abs_b      = b[WORD-1] ? -b : b;
    assign div_n      = (op == OP_DIV) ? abs_a : a;
    assign div_d      = (op == OP_DIV) ? abs_b : b;
    assign div_d_safe = (div_d == '0) ? {{(WORD-1){1'b0}}, 1'b1} : div_d;
    assign quo_u      = div_n / div_d_safe;
    assign rem_u      = div_n % div_d_safe;

    alu_isqrt u_isqrt (
        .radicand (a),
        .root     (sqrt_root)
    );

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (op)
            OP_SLA: begin
                result_d   = {a[WORD-2:0], 1'b0};
                overflow_d = a[WORD-1] ^ a[WORD-2];
            end
            OP_SRAI: result_d = {a[WORD-1], a[WORD-1:1]};
            OP_ADD, OP_ADDI: begin
                result_d   = sum;
                overflow_d = (a[WORD-1] == op_b[WORD-1]) && (sum[WORD-1] != a[WORD-1]);
            end
            OP_SUB: begin
                result_d   = diff;
                overflow_d = (a[WORD-1] != op_b[WORD-1]) && (diff[WORD-1] != a[WORD-1]);
            end
            OP_ADDU, OP_ADDIU: result_d = sum;
            OP_SUBU:           result_d = diff;
            OP_MULT: begin
                hi_d     = prod_s[63:32];
                lo_d     = prod_s[31:0];
                result_d = prod_s[31:0];
            end
            OP_MULTU: begin
                hi_d     = prod_u[63:32];
                lo_d     = prod_u[31:0];
                result_d = prod_u[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (b == '0) begin
                    hi_d       = '0;
                    lo_d       = '0;
                    overflow_d = 1'b1;
                end else if (op == OP_DIV) begin
                    lo_d       = (a[WORD-1] ^ b[WORD-1]) ? -quo_u : quo_u;
                    hi_d       = a[WORD-1] ? -rem_u : rem_u;
                    // Only -2^31 / -1 leaves a positive magnitude that does not fit.
                    overflow_d = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
                end else begin
                    lo_d = quo_u;
                    hi_d = rem_u;
                end
                result_d = lo_d;
            end
            OP_SQRT: result_d = {{(WORD/2){1'b0}}, sqrt_root};
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_NOR:  result_d = ~(a | b);
            OP_XOR:  result_d = a ^ b;
            OP_XNOR: result_d = ~(a ^ b);
            OP_ANDI: result_d = a & op_b;
            OP_ORI:  result_d = a | op_b;
            OP_SLT, OP_SLTI: result_d = {{(WORD-1){1'b0}}, ($signed(a) < $signed(op_b))};
            default: begin
                result_d   = '0;
                overflow_d = 1'b0;
            end
        endcase
    end

    assign zero_d = (result_d == '0);
    assign neg_d  = result_d[WORD-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_A      <= '0;
            reg_B      <= '0;
            reg_C      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            reg_A      <= a;
            reg_B      <= op_b;
            reg_C      <= result_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
            neg_q      <= neg_d;
        end
    end

    assign c        = reg_C;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign neg      = neg_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: arithmetic reference model plus hand-computed directed vectors.
module tb_alu;
    import alu_pkg::*;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [15:0] immediate;
    logic [4:0]  opcode;
    logic [31:0] c, HI, LO;
    logic        zero, overflow, neg;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_c, m_hi, m_lo;
    logic        m_ovf, m_zero, m_neg;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .immediate (immediate),
        .opcode    (opcode),
        .c         (c),
        .HI        (HI),
        .LO        (LO),
        .zero      (zero),
        .overflow  (overflow),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    // Reference model: plain 64-bit arithmetic on the operation's mathematical definition.
    function automatic void model_eval(input logic [4:0] op, input logic [31:0] x, y,
                                       input logic [15:0] imm,
                                       inout logic [31:0] hi, lo,
                                       output logic [31:0] res, output logic ovf);
        longint          sx, sy, simm_l, sr, sq;
        longint unsigned ux, uy, up, root;
        real             rt;
        sx     = longint'($signed(x));
        sy     = longint'($signed(y));
        simm_l = longint'($signed(imm));
        ux     = {32'h0, x};
        uy     = {32'h0, y};
        res    = '0;
        ovf    = 1'b0;
        case (op)
            OP_SLA:   begin sr = 2 * sx; res = sr[31:0]; ovf = (sr > SMAX) || (sr < SMIN); end
            OP_SRAI:  res = 32'($signed(x) >>> 1);
            OP_ADD:   begin sr = sx + sy; res = sr[31:0]; ovf = (sr > SMAX) || (sr < SMIN); end
            OP_SUB:   begin sr = sx - sy; res = sr[31:0]; ovf = (sr > SMAX) || (sr < SMIN); end
            OP_ADDI:  begin sr = sx + simm_l; res = sr[31:0]; ovf = (sr > SMAX) || (sr < SMIN); end
            OP_ADDU:  begin up = ux + uy; res = up[31:0]; end
            OP_SUBU:  begin up = ux - uy; res = up[31:0]; end
            OP_ADDIU: begin sr = sx + simm_l; res = sr[31:0]; end
            OP_MULT:  begin sr = sx * sy; hi = sr[63:32]; lo = sr[31:0]; res = lo; end
            OP_MULTU: begin up = ux * uy; hi = up[63:32]; lo = up[31:0]; res = lo; end
            OP_DIV, OP_DIVU: begin
                if (y == 32'h0) begin
                    hi = '0; lo = '0; ovf = 1'b1;
                end else if (op == OP_DIV) begin
                    sq = sx / sy; sr = sx % sy;
                    lo = sq[31:0]; hi = sr[31:0];
                    ovf = (sq > SMAX);
                end else begin
                    up = ux / uy; root = ux % uy;
                    lo = up[31:0]; hi = root[31:0];
                end
                res = lo;
            end
            OP_SQRT: begin
                rt   = $sqrt(real'(ux));
                root = longint'($floor(rt));
                while (root * root > ux) root--;
                while ((root + 1) * (root + 1) <= ux) root++;
                res = root[31:0];
            end
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_NOR:  res = ~(x | y);
            OP_XOR:  res = x ^ y;
            OP_XNOR: res = ~(x ^ y);
            OP_ANDI: res = x & {16'h0, imm};
            OP_ORI:  res = x | {16'h0, imm};
            OP_SLT:  res = (sx < sy) ? 32'd1 : 32'd0;
            OP_SLTI: res = (sx < simm_l) ? 32'd1 : 32'd0;
            default: begin res = '0; ovf = 1'b0; end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_c = '0; m_hi = '0; m_lo = '0;
            m_ovf = 1'b0; m_zero = 1'b0; m_neg = 1'b0;
        end else begin
            model_eval(opcode, a, b, immediate, m_hi, m_lo, m_c, m_ovf);
            m_zero = (m_c == 32'h0);
            m_neg  = m_c[31];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle the outputs are meaningful, compare them with the model away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_c", c, m_c);
            checkOutput("model_HI", HI, m_hi);
            checkOutput("model_LO", LO, m_lo);
            checkOutput("model_zero", {31'b0, zero}, {31'b0, m_zero});
            checkOutput("model_overflow", {31'b0, overflow}, {31'b0, m_ovf});
            checkOutput("model_neg", {31'b0, neg}, {31'b0, m_neg});
        end
    end

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] x, y, input logic [15:0] imm);
        @(negedge clk);
        opcode    = op;
        a         = x;
        b         = y;
        immediate = imm;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tab_a [6] = '{32'h0, 32'h7, 32'h8000_0000, 32'hFFFF_FFF9, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] tab_b [6] = '{32'h0, 32'h3, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'hFFFF_FFFF};
    logic [15:0] tab_i [6] = '{16'h0, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h00F0, 16'h1234};

    initial begin
        rst_n = 1'b0; a = '0; b = '0; immediate = '0; opcode = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_c", c, 32'h0);
        checkOutput("reset_HI", HI, 32'h0);
        checkOutput("reset_LO", LO, 32'h0);
        checkOutput("reset_zero", {31'b0, zero}, 32'h0);
        checkOutput("reset_overflow", {31'b0, overflow}, 32'h0);
        checkOutput("reset_neg", {31'b0, neg}, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        applyStimulus(OP_ADD, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0);
        checkOutput("add_c", c, 32'h7FFF_FFFF);
        checkOutput("add_ovf", {31'b0, overflow}, 32'h1);
        applyStimulus(OP_SUB, 32'h1, 32'hFFFF_FFFF, 16'h0);
        checkOutput("sub_c", c, 32'h2);
        checkOutput("sub_ovf", {31'b0, overflow}, 32'h0);

        applyStimulus(OP_MULT, 32'h8000_0002, 32'h2, 16'h0);
        checkOutput("mult_HI", HI, 32'hFFFF_FFFF);
        checkOutput("mult_LO", LO, 32'h0000_0004);
        applyStimulus(OP_MULTU, 32'h8000_0002, 32'h2, 16'h0);
        checkOutput("multu_HI", HI, 32'h0000_0001);
        checkOutput("multu_LO", LO, 32'h0000_0004);
        applyStimulus(OP_ADD, 32'h5, 32'h6, 16'h0);
        checkOutput("hold_HI", HI, 32'h0000_0001);
        checkOutput("hold_LO", LO, 32'h0000_0004);
        applyStimulus(OP_DIV, 32'd9, 32'd2, 16'h0);
        checkOutput("div_LO", LO, 32'd4);
        checkOutput("div_HI", HI, 32'd1);
        applyStimulus(OP_DIV, 32'hFFFF_FFF7, 32'd2, 16'h0);
        checkOutput("div_neg_LO", LO, 32'hFFFF_FFFC);
        checkOutput("div_neg_HI", HI, 32'hFFFF_FFFF);
        applyStimulus(OP_DIVU, 32'h8000_0001, 32'h8000_0001, 16'h0);
        checkOutput("divu_LO", LO, 32'd1);
        checkOutput("divu_HI", HI, 32'd0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 16'h0);
        checkOutput("divmin_LO", LO, 32'h8000_0000);
        checkOutput("divmin_HI", HI, 32'h0);
        checkOutput("divmin_ovf", {31'b0, overflow}, 32'h1);

        applyStimulus(OP_ADDI, 32'h1, 32'h0, 16'hFFFF);
        checkOutput("addi_c", c, 32'h0);
        checkOutput("addi_zero", {31'b0, zero}, 32'h1);
        applyStimulus(OP_ADDU, 32'h8000_0001, 32'h8000_0001, 16'h0);
        checkOutput("addu_c", c, 32'h2);
        checkOutput("addu_ovf", {31'b0, overflow}, 32'h0);
        applyStimulus(OP_SUBU, 32'h1, 32'h8000_0000, 16'h0);
        checkOutput("subu_c", c, 32'h8000_0001);
        checkOutput("subu_neg", {31'b0, neg}, 32'h1);

        applyStimulus(OP_SLA, 32'hDDDD_DDDD, 32'h0, 16'h0);
        checkOutput("sla1_c", c, 32'hBBBB_BBBA);
        checkOutput("sla1_ovf", {31'b0, overflow}, 32'h0);
        applyStimulus(OP_SLA, 32'h4040_4040, 32'h0, 16'h0);
        checkOutput("sla2_c", c, 32'h8080_8080);
        checkOutput("sla2_ovf", {31'b0, overflow}, 32'h1);
        applyStimulus(OP_SRAI, 32'hFDFD_FDFD, 32'h0, 16'h0);
        checkOutput("srai_c", c, 32'hFEFE_FEFE);

        applyStimulus(OP_OR, 32'h6, 32'h7, 16'h0);   checkOutput("or_c", c, 32'h7);
        applyStimulus(OP_NOR, 32'h6, 32'h7, 16'h0);  checkOutput("nor_c", c, 32'hFFFF_FFF8);
        applyStimulus(OP_XOR, 32'h6, 32'h7, 16'h0);  checkOutput("xor_c", c, 32'h1);
        applyStimulus(OP_XNOR, 32'h6, 32'h7, 16'h0); checkOutput("xnor_c", c, 32'hFFFF_FFFE);
        applyStimulus(OP_ANDI, 32'h6, 32'h7, 16'hFFFF); checkOutput("andi_c", c, 32'h6);
        applyStimulus(OP_ORI, 32'h6, 32'h7, 16'hFFFF);  checkOutput("ori_c", c, 32'h0000_FFFF);
        applyStimulus(OP_SLT, 32'h6, 32'h7, 16'h0);     checkOutput("slt_c", c, 32'h1);
        applyStimulus(OP_SLTI, 32'h6, 32'h7, 16'hFFFF); checkOutput("slti_c", c, 32'h0);

        applyStimulus(OP_DIV, 32'd10, 32'd0, 16'h0);
        checkOutput("div0_ovf", {31'b0, overflow}, 32'h1);
        checkOutput("div0_HI", HI, 32'h0);
        checkOutput("div0_LO", LO, 32'h0);
        applyStimulus(OP_SQRT, 32'hFFFF_FFFF, 32'h0, 16'h0);
        checkOutput("sqrt_max_c", c, 32'h0000_FFFF);
        applyStimulus(OP_SQRT, 32'd99, 32'h0, 16'h0);
        checkOutput("sqrt_99_c", c, 32'd9);

        applyStimulus(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 16'h0);
        applyStimulus(5'h1A, 32'h1234, 32'h5678, 16'h0);
        checkOutput("undef_c", c, 32'h0);
        checkOutput("undef_HI", HI, 32'h1);

        applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_c", c, 32'h0);
        checkOutput("midreset_HI", HI, 32'h0);
        checkOutput("midreset_LO", LO, 32'h0);
        checkOutput("midreset_neg", {31'b0, neg}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int op = 0; op < 32; op++) begin
            for (int k = 0; k < 6; k++) begin
                applyStimulus(5'(op), tab_a[k], tab_b[k], tab_i[k]);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
